serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  operand A (two's complement or unsigned).
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: sub  input  1  subtract request, sampled with a/b; see Configuration.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: sum  output  WIDTH  result.
REQ-012 SHALL have port: cout  output  1  carry out of MSB.
REQ-013 SHALL have port: overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready SHALL load a/b into shift registers, load carry flop with effective sub, load bit counter with WIDTH, go to RUN.
REQ-017 RUN: each cycle SHALL add LSB of A, LSB of B (inverted if effective sub) and carry flop, shift sum bit into result MSB, shift A/B right one bit, update carry, decrement counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; the counter reaching 0 SHALL move to DONE; out_valid SHALL rise on the edge WIDTH cycles after the acceptance edge.
REQ-019 SHALL capture the carry into bit WIDTH-1 during the last RUN cycle for overflow; for WIDTH=1 carry-in to MSB is the initial carry.
REQ-020 DONE: sum, cout, overflow SHALL hold stable while out_ready=0; on out_ready=1 SHALL return to IDLE.
REQ-021 SHALL not accept new operands in the cycle the result handshake completes (in_ready rises one cycle later).
REQ-022 Inputs a, b, sub SHALL be ignored outside the accepting cycle.
REQ-023 Counter SHALL be $clog2(WIDTH+1) bits; no wrap beyond 0.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, sum=0, cout=0, overflow=0, carry/shift/counter=0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation; no partial result SHALL ever appear on out_valid.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN defined: effective sub = sub, computing a - b (B inverted, initial carry 1); cout=1 means no borrow.
REQ-027 Macro undefined: effective sub = 0, sub port present but ignored, block is add-only.

Structure
REQ-028 Shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default width constant.
REQ-029 The per-bit add SHALL instantiate the existing 1-bit full adder yAdder1 (z, cout, a, b, cin) as the only sub-module.

Verification
REQ-030 WIDTH=8, a=0x0F, b=0x01, sub=0 -> after 8 RUN cycles out_valid=1, sum=0x10, cout=0, overflow=0.
REQ-031 a=0xFF, b=0x01 -> sum=0x00, cout=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
REQ-032 With SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; without macro same stimulus -> sum=0x0C.
REQ-033 out_ready held low 5 cycles in DONE -> out_valid and sum stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready handshake.
REQ-034 rst_n pulsed low at RUN cycle 4 -> out_valid never asserts, next transaction a=0x03, b=0x04 -> sum=0x07.
REQ-035 WIDTH=1 exhaustive a,b,sub over {0,1} -> sum/cout match 1-bit full-adder truth table after 1 RUN cycle.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default operand width
// for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Legacy-compatible state encoding kept as explicit constants
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/yAdder1.sv
// yAdder1: 1-bit full adder used as the per-bit datapath of serial_adder.
module yAdder1 (
    output logic z,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign z    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first, one bit per cycle,
// valid/ready handshake on operands and on the result.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN;
// without it the sub port is ignored and the block is add-only.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eff_sub;
    logic             fa_z, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign eff_sub = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign eff_sub    = 1'b0;
`endif

    // B is inverted on the fly so the shift register always holds the raw operand
    yAdder1 u_fa (
        .z   (fa_z),
        .cout(fa_c),
        .a   (a_q[0]),
        .b   (b_q[0] ^ sub_q),
        .cin (carry_q)
    );

    // Next-state and datapath: load on accept, one bit per RUN cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = eff_sub;
                    carry_d = eff_sub;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = fa_z;
                carry_d          = fa_c;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                // Last bit: carry_q is the carry into the MSB
                if (cnt_q == CW'(1)) begin
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = res_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
    logic [W-1:0] a, b, sum;

    logic         in_valid1, in_ready1, sub1, out_valid1, cout1, ovf1;
    logic         out_ready1;
    logic [0:0]   a1, b1, sum1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    serial_adder #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    function automatic logic eff_of(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        return s;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: a + b (or a - b as a + ~b + 1), modulo 2^w, with signed range test
    function automatic exp_t model(input int unsigned w, input logic [31:0] x,
                                   input logic [31:0] y, input logic s);
        exp_t    r;
        longint  m, ux, uy, tot, sx, sy, ss, e;
        e   = eff_of(s) ? 64'sd1 : 64'sd0;
        m   = longint'(1) << w;
        ux  = longint'(x);
        uy  = (e == 1) ? (m - 1 - longint'(y)) : longint'(y);
        tot = ux + uy + e;
        r.s = 32'(tot % m);
        r.c = (tot >= m);
        sx  = (ux >= m / 2) ? ux - m : ux;
        sy  = (uy >= m / 2) ? uy - m : uy;
        ss  = sx + sy + e;
        r.v = (ss < -(m / 2)) || (ss >= m / 2);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // WIDTH=8 monitor: compare on each completed result handshake
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result8: got sum=%0h with nothing expected", sum);
            end else begin
                e = q8.pop_front();
                check("sum8", 32'(sum), e.s);
                check("cout8", 32'(cout), 32'(e.c));
                check("ovf8", 32'(overflow), 32'(e.v));
            end
        end
    end

    // WIDTH=1 monitor
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result1: got sum=%0h with nothing expected", sum1);
            end else begin
                e = q1.pop_front();
                check("sum1", 32'(sum1), e.s);
                check("cout1", 32'(cout1), 32'(e.c));
                check("ovf1", 32'(ovf1), 32'(e.v));
            end
        end
    end

    task automatic wait_ready8();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout8", 32'(in_ready), 32'd1);
    endtask

    // One WIDTH=8 transaction; result held 'hold' cycles before out_ready
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, input int hold);
        int n;
        logic [W-1:0] snap;
        logic snapc;
        wait_ready8();
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        q8.push_back(model(W, 32'(ta), 32'(tb), ts));
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency8", 32'(n), 32'(W));
        snap  = sum;
        snapc = cout;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(snap));
            check("hold_cout", 32'(cout), 32'(snapc));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("ready_before_hs", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ready_after_hs", 32'(in_ready), 32'd1);
        check("valid_after_hs", 32'(out_valid), 32'd0);
    endtask

    task automatic do_op1(input logic ta, input logic tb, input logic ts);
        int n = 0;
        while (!in_ready1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready1) check("ready_timeout1", 32'(in_ready1), 32'd1);
        a1 = ta; b1 = tb; sub1 = ts; in_valid1 = 1'b1;
        @(posedge clk); #1;
        q1.push_back(model(1, 32'(ta), 32'(tb), ts));
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency1", 32'(n), 32'd1);
        @(posedge clk); #1;
        check("ready_after_hs1", 32'(in_ready1), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; sub1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);

        do_op(8'h0F, 8'h01, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1);
        do_op(8'h7F, 8'h01, 1'b0, 0);
        do_op(8'h05, 8'h07, 1'b1, 5);
        do_op(8'h80, 8'h80, 1'b0, 2);
        do_op(8'h80, 8'h01, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort an operation mid-RUN: nothing may ever be presented for it
        wait_ready8();
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 2 * int'(W); i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        do_op(8'h03, 8'h04, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            do_op1(1'(i), 1'(i >> 1), 1'(i >> 2));
        end

        repeat (3) @(posedge clk);
        #1;
        check("drain8", 32'(q8.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
